// File: rtl/shift_add_multiplier.sv
// Sequential shift-and-add multiplier: AQ = Q*D (+ Rem when REM_ACCUM_EN is defined).
// One iteration per clock, N iterations per operation, registered result and Done pulse.
// Optional feature macro: REM_ACCUM_EN. When it is defined, A is preloaded with Rem so that
// the result is the full dividend Q*D+Rem. When it is undefined, Rem is ignored.
module shift_add_multiplier #(
    parameter int unsigned N = 6
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   Q,
    input  logic [N-1:0]   D,
    input  logic [N-1:0]   Rem,
    output logic [2*N-1:0] AQ,
    output logic           Done
);

    // Three bits cover the default width; wider operands need a wider iteration counter.
    localparam int unsigned CntW = (N > 8) ? $clog2(N) : 3;

    typedef enum logic [1:0] {StIdle, StRun, StDone, StWait} state_e;

    state_e           state_q, state_d;
    logic [N-1:0]     m_q, a_q, qr_q;
    logic [CntW-1:0]  cnt_q;
    logic [2*N-1:0]   aq_q;
    logic             done_q;

    logic [N-1:0]     a_init;
    logic [N:0]       sum;
    logic [N-1:0]     a_next, qr_next;
    logic             last_iter;

`ifdef REM_ACCUM_EN
    assign a_init = Rem;
`else
    logic unused_rem;
    assign a_init     = '0;
    assign unused_rem = ^Rem;
`endif

    // One add-then-shift step: the carry of the N+1-bit add becomes the new MSB of A.
    always_comb begin
        sum       = {1'b0, a_q} + (qr_q[0] ? {1'b0, m_q} : {(N+1){1'b0}});
        a_next    = sum[N:1];
        qr_next   = {sum[0], qr_q[N-1:1]};
        last_iter = (cnt_q == CntW'(N - 1));
    end

    // Next-state logic; WAIT absorbs a start that is still held after completion.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (last_iter) state_d = StDone;
            StDone:  state_d = start ? StWait : StIdle;
            StWait:  if (!start) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand capture and iteration datapath; operands are only sampled in IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_q   <= '0;
            a_q   <= '0;
            qr_q  <= '0;
            cnt_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        m_q   <= D;
                        qr_q  <= Q;
                        a_q   <= a_init;
                        cnt_q <= '0;
                    end
                end
                StRun: begin
                    a_q   <= a_next;
                    qr_q  <= qr_next;
                    cnt_q <= cnt_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Result register loads on the edge entering DONE; Done is high only while in DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            aq_q   <= '0;
            done_q <= 1'b0;
        end else begin
            if (state_q == StRun && last_iter) begin
                aq_q <= {a_next, qr_next};
            end
            done_q <= (state_d == StDone);
        end
    end

    assign AQ   = aq_q;
    assign Done = done_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench for shift_add_multiplier: the driver pushes expected results computed
// with plain arithmetic, and a monitor pops and checks them whenever Done is seen.
module tb_shift_add_multiplier;

    localparam int unsigned N = 6;
    localparam int unsigned W = 2 * N;

    logic         clk   = 1'b0;
    logic         rst   = 1'b1;
    logic         start = 1'b0;
    logic [N-1:0] Q     = '0;
    logic [N-1:0] D     = '0;
    logic [N-1:0] Rem   = '0;
    logic [W-1:0] AQ;
    logic         Done;

    shift_add_multiplier #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .Q     (Q),
        .D     (D),
        .Rem   (Rem),
        .AQ    (AQ),
        .Done  (Done)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] aq;
        int unsigned  cyc;
    } exp_t;

    exp_t sb[$];
    int   tests     = 0;
    int   fails     = 0;
    int   done_seen = 0;

    function automatic logic [W-1:0] ref_model(input logic [N-1:0] q, input logic [N-1:0] d,
                                               input logic [N-1:0] r);
        int unsigned p;
        p = int'(q) * int'(d);
`ifdef REM_ACCUM_EN
        p = p + int'(r);
`else
        if (r == r) p = p + 0;
`endif
        return W'(p);
    endfunction

    // Monitor: checks every completion against the scoreboard and that AQ holds otherwise.
    logic [W-1:0] held = '0;
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst) begin
            held = '0;
        end else if (Done) begin
            done_seen++;
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_done: AQ=%0d, required no Done pulse", AQ);
            end else begin
                e    = sb.pop_front();
                held = e.aq;
                if (AQ !== e.aq) begin
                    fails++;
                    $display("FAIL result: AQ=%0d, required %0d", AQ, e.aq);
                end
                tests++;
                if (cyc != e.cyc + N) begin
                    fails++;
                    $display("FAIL latency: Done at cycle %0d, required %0d", cyc, e.cyc + N);
                end
            end
        end else begin
            tests++;
            if (AQ !== held) begin
                fails++;
                $display("FAIL aq_hold: AQ=%0d, required %0d", AQ, held);
            end
        end
    end

    task automatic wait_done(input int seen0);
        int k;
        for (k = 0; k < 60; k++) begin
            if (done_seen > seen0) break;
            @(negedge clk);
        end
        if (done_seen <= seen0) begin
            tests++;
            fails++;
            $display("FAIL timeout: no Done within 60 cycles, required one");
        end
    endtask

    task automatic run_op(input logic [N-1:0] q, input logic [N-1:0] d, input logic [N-1:0] r,
                          input int hold);
        int seen0;
        @(negedge clk);
        Q = q; D = d; Rem = r; start = 1'b1;
        sb.push_back('{ref_model(q, d, r), cyc + 1});
        seen0 = done_seen;
        repeat (hold) @(negedge clk);
        start = 1'b0;
        wait_done(seen0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int seen0;
        logic [N-1:0] r;

        // Asynchronous reset: outputs clear without a clock edge.
        #2 rst = 1'b0;
        #1;
        tests += 2;
        if (AQ !== '0) begin fails++; $display("FAIL reset_aq: AQ=%0d, required 0", AQ); end
        if (Done !== 1'b0) begin fails++; $display("FAIL reset_done: Done=%0b, required 0", Done); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Directed cases, including a start held for two cycles.
        run_op(6'd11, 6'd8, 6'd0, 2);
        run_op(6'd6, 6'd11, 6'd9, 1);
        run_op(6'd39, 6'd51, 6'd11, 1);
        run_op(6'd33, 6'd56, 6'd28, 1);
        run_op(6'd63, 6'd63, 6'd63, 1);
        r = 6'($urandom_range(0, 63));
        run_op(6'd0, 6'd45, r, 1);
        run_op(6'd45, 6'd0, 6'd17, 1);

        // Reset three cycles into RUN; a start held through release is taken on the first edge.
        @(negedge clk);
        Q = 6'd21; D = 6'd17; Rem = 6'd3; start = 1'b1;
        sb.push_back('{ref_model(6'd21, 6'd17, 6'd3), cyc + 1});
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        sb.delete();
        #1;
        tests += 2;
        if (AQ !== '0) begin fails++; $display("FAIL midrun_reset_aq: AQ=%0d, required 0", AQ); end
        if (Done !== 1'b0) begin fails++; $display("FAIL midrun_reset_done: Done=%0b, required 0", Done); end
        @(negedge clk);
        Q = 6'd5; D = 6'd7; Rem = 6'd0; start = 1'b1;
        @(negedge clk);
        sb.push_back('{ref_model(6'd5, 6'd7, 6'd0), cyc + 1});
        seen0 = done_seen;
        rst = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(seen0);
        repeat (2) @(negedge clk);

        // Operands and start change during RUN; only the captured values count.
        @(negedge clk);
        Q = 6'd27; D = 6'd38; Rem = 6'd14; start = 1'b1;
        sb.push_back('{ref_model(6'd27, 6'd38, 6'd14), cyc + 1});
        seen0 = done_seen;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            Q = 6'($urandom); D = 6'($urandom); Rem = 6'($urandom);
            start = i[0];
        end
        @(negedge clk);
        start = 1'b0;
        wait_done(seen0);
        repeat (2) @(negedge clk);

        // Start held for 20 cycles yields a single completion.
        run_op(6'd50, 6'd41, 6'd22, 20);

        // Randomized operations.
        for (int i = 0; i < 40; i++) begin
            run_op(6'($urandom), 6'($urandom), 6'($urandom), int'($urandom_range(1, 3)));
        end

        repeat (10) @(negedge clk);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d results pending, required 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
